branch_predict_local_param: RTL

Parametrised two-level local branch predictor for the five-stage MIPS pipeline. It generalises the fixed local predictor in table depth, history length and counter width, and adds a reset-time table-initialisation sweep with a `ready` indication. It predicts in F from `pcF` and is trained in M with the resolved branch outcome.

---
 rtl/bp_pkg.sv | 36 +++
 rtl/branch_predict_local_param_if.sv | 45 ++++
 rtl/bp_table.sv | 29 ++
 rtl/branch_predict_local_param.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the parametrised local branch predictor: default sizes,
// FSM state type and the saturating-counter step.
package bp_pkg;

    localparam int DEF_PC_HASH_BITS = 6;
    localparam int DEF_HIST_BITS    = 6;
    localparam int DEF_CTR_BITS     = 2;
    localparam int MAX_CTR_BITS     = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_t;

    // Counters are carried at the widest legal width.
    // ctrMax is the saturation ceiling for the instance's real counter width.
    function automatic logic [MAX_CTR_BITS-1:0] ctr_next(
        input logic [MAX_CTR_BITS-1:0] ctr,
        input logic                    taken,
        input logic [MAX_CTR_BITS-1:0] ctrMax
    );
        logic [MAX_CTR_BITS-1:0] result;
        result = ctr;
        if (taken) begin
            if (ctr < ctrMax) begin
                result = ctr + MAX_CTR_BITS'(1);
            end
        end else begin
            if (ctr != '0) begin
                result = ctr - MAX_CTR_BITS'(1);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_predict_local_param_if.sv
// Fetch/memory-stage connection to the local branch predictor. The counter
// outputs exist only when BP_STATS_EN is defined.
interface branch_predict_local_param_if
    import bp_pkg::*;
#(
    parameter int PC_HASH_BITS = DEF_PC_HASH_BITS,
    parameter int HIST_BITS    = DEF_HIST_BITS
);

    logic [31:0]             pcF;
    logic                    branchM;
    logic [PC_HASH_BITS-1:0] BHT_indexM;
    logic [HIST_BITS-1:0]    PHT_indexM;
    logic                    actually_takenM;
    logic                    predict_resultM;
    logic                    predict_takeF;
    logic [PC_HASH_BITS-1:0] pc_hashingF;
    logic [HIST_BITS-1:0]    PHT_indexF;
    logic                    ready;
`ifdef BP_STATS_EN
    logic [31:0]             branch_cnt;
    logic [31:0]             mispredict_cnt;

    modport master (
        output pcF, branchM, BHT_indexM, PHT_indexM, actually_takenM, predict_resultM,
        input  predict_takeF, pc_hashingF, PHT_indexF, ready, branch_cnt, mispredict_cnt
    );

    modport slave (
        input  pcF, branchM, BHT_indexM, PHT_indexM, actually_takenM, predict_resultM,
        output predict_takeF, pc_hashingF, PHT_indexF, ready, branch_cnt, mispredict_cnt
    );
`else
    modport master (
        output pcF, branchM, BHT_indexM, PHT_indexM, actually_takenM, predict_resultM,
        input  predict_takeF, pc_hashingF, PHT_indexF, ready
    );

    modport slave (
        input  pcF, branchM, BHT_indexM, PHT_indexM, actually_takenM, predict_resultM,
        output predict_takeF, pc_hashingF, PHT_indexF, ready
    );
`endif

endinterface

// File: rtl/bp_table.sv
// DEPTH x WIDTH predictor table: one synchronous write port, asynchronous reads.
// The second read port feeds the read-modify-write path for training.
module bp_table #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 6,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    input  logic [AW-1:0]    rmwAddr,
    output logic [WIDTH-1:0] rmwData
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata   = mem[raddr];
    assign rmwData = mem[rmwAddr];

endmodule

// File: rtl/branch_predict_local_param.sv
// Two-level local branch predictor with a reset-time table-clearing sweep.
// Optional event counters are built when BP_STATS_EN is defined.
module branch_predict_local_param
    import bp_pkg::*;
#(
    parameter int PC_HASH_BITS = DEF_PC_HASH_BITS,
    parameter int HIST_BITS    = DEF_HIST_BITS,
    parameter int CTR_BITS     = DEF_CTR_BITS
) (
    input  logic clk,
    input  logic rst,
    branch_predict_local_param_if.slave bp
);

    localparam int BHT_DEPTH = 1 << PC_HASH_BITS;
    localparam int PHT_DEPTH = 1 << HIST_BITS;
    localparam int IDX_BITS  = (PC_HASH_BITS > HIST_BITS) ? PC_HASH_BITS : HIST_BITS;

    localparam logic [CTR_BITS-1:0]     CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [MAX_CTR_BITS-1:0] CTR_MAX  = MAX_CTR_BITS'((1 << CTR_BITS) - 1);

    bp_state_t           stateReg;
    logic [IDX_BITS-1:0] initIdxReg;
    logic                readyReg;

    logic [PC_HASH_BITS-1:0] pcHash;
    logic [HIST_BITS-1:0]    bhtLookup;
    logic [HIST_BITS-1:0]    bhtRmw;
    logic [CTR_BITS-1:0]     phtLookup;
    logic [CTR_BITS-1:0]     phtRmw;

    logic                    bhtWe;
    logic [PC_HASH_BITS-1:0] bhtWaddr;
    logic [HIST_BITS-1:0]    bhtWdata;
    logic                    phtWe;
    logic [HIST_BITS-1:0]    phtWaddr;
    logic [CTR_BITS-1:0]     phtWdata;

    logic trainEn;
    logic initBhtEn;
    logic initPhtEn;

    // Sweep covers the deeper table; the shallower one stops writing once
    // the index runs past its depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg   <= INIT;
            initIdxReg <= '0;
            readyReg   <= 1'b0;
        end else begin
            case (stateReg)
                INIT: begin
                    initIdxReg <= initIdxReg + IDX_BITS'(1);
                    if (initIdxReg == '1) begin
                        stateReg <= RUN;
                        readyReg <= 1'b1;
                    end
                end
                RUN: begin
                    stateReg <= RUN;
                end
                default: begin
                    stateReg   <= INIT;
                    initIdxReg <= '0;
                    readyReg   <= 1'b0;
                end
            endcase
        end
    end

    assign pcHash    = bp.pcF[PC_HASH_BITS+1:2];
    assign trainEn   = bp.branchM && readyReg && !rst;
    assign initBhtEn = (stateReg == INIT) && ((initIdxReg >> PC_HASH_BITS) == '0);
    assign initPhtEn = (stateReg == INIT) && ((initIdxReg >> HIST_BITS) == '0);

    always_comb begin
        bhtWe    = 1'b0;
        bhtWaddr = bp.BHT_indexM;
        bhtWdata = HIST_BITS'({bhtRmw, bp.actually_takenM});
        phtWe    = 1'b0;
        phtWaddr = bp.PHT_indexM;
        phtWdata = CTR_BITS'(ctr_next(MAX_CTR_BITS'(phtRmw), bp.actually_takenM, CTR_MAX));
        if (stateReg == INIT) begin
            bhtWe    = initBhtEn;
            bhtWaddr = initIdxReg[PC_HASH_BITS-1:0];
            bhtWdata = '0;
            phtWe    = initPhtEn;
            phtWaddr = initIdxReg[HIST_BITS-1:0];
            phtWdata = CTR_INIT;
        end else begin
            bhtWe = trainEn;
            phtWe = trainEn;
        end
    end

    bp_table #(
        .DEPTH (BHT_DEPTH),
        .WIDTH (HIST_BITS),
        .AW    (PC_HASH_BITS)
    ) bhtTable (
        .clk     (clk),
        .we      (bhtWe),
        .waddr   (bhtWaddr),
        .wdata   (bhtWdata),
        .raddr   (pcHash),
        .rdata   (bhtLookup),
        .rmwAddr (bp.BHT_indexM),
        .rmwData (bhtRmw)
    );

    bp_table #(
        .DEPTH (PHT_DEPTH),
        .WIDTH (CTR_BITS),
        .AW    (HIST_BITS)
    ) phtTable (
        .clk     (clk),
        .we      (phtWe),
        .waddr   (phtWaddr),
        .wdata   (phtWdata),
        .raddr   (bhtLookup),
        .rdata   (phtLookup),
        .rmwAddr (bp.PHT_indexM),
        .rmwData (phtRmw)
    );

    // Tables hold garbage until the sweep finishes, so lookups are masked.
    assign bp.pc_hashingF   = pcHash;
    assign bp.PHT_indexF    = readyReg ? bhtLookup : '0;
    assign bp.predict_takeF = readyReg & phtLookup[CTR_BITS-1];
    assign bp.ready         = readyReg;

`ifdef BP_STATS_EN
    logic [31:0] branchCntReg;
    logic [31:0] mispredictCntReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            branchCntReg     <= '0;
            mispredictCntReg <= '0;
        end else if (trainEn) begin
            branchCntReg <= branchCntReg + 32'd1;
            if (bp.predict_resultM != bp.actually_takenM) begin
                mispredictCntReg <= mispredictCntReg + 32'd1;
            end
        end
    end

    assign bp.branch_cnt     = branchCntReg;
    assign bp.mispredict_cnt = mispredictCntReg;

    logic unusedBits;
    assign unusedBits = ^{bp.pcF[31:PC_HASH_BITS+2], bp.pcF[1:0], phtLookup};
`else
    logic unusedBits;
    assign unusedBits = ^{bp.pcF[31:PC_HASH_BITS+2], bp.pcF[1:0], phtLookup, bp.predict_resultM};
`endif

endmodule
